// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic adder run controller.
// Holds the FSM state encoding and the default carry-counter ceiling.
package stoch_pkg;

    localparam int COUNTER_SIZE_DEF = 8;
    localparam int CNT_MAX          = (1 << COUNTER_SIZE_DEF) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/stoch_add_core.sv
// Saturating carry counter of the stochastic bitstream adder.
// Emits one output bit per enabled step and keeps the leftover carry.
module stoch_add_core #(
    parameter int COUNTER_SIZE = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_a,
    input  logic                    i_b,
    output logic                    o_yc,
    output logic [COUNTER_SIZE-1:0] o_cnt_nxt,
    output logic                    o_sat
);

    logic [COUNTER_SIZE-1:0] r_cnt;
    logic [COUNTER_SIZE:0]   w_c;
    logic [COUNTER_SIZE:0]   w_d;

    // Add both operand bits to the carry, emit a one if anything is held,
    // and clamp the remaining carry at the counter ceiling.
    always_comb begin
        w_c       = {1'b0, r_cnt}
                  + {{COUNTER_SIZE{1'b0}}, i_a}
                  + {{COUNTER_SIZE{1'b0}}, i_b};
        o_yc      = (w_c != '0);
        w_d       = w_c - {{COUNTER_SIZE{1'b0}}, o_yc};
        o_sat     = w_d[COUNTER_SIZE];
        o_cnt_nxt = o_sat ? {COUNTER_SIZE{1'b1}}
                          : w_d[COUNTER_SIZE-1:0];
    end

    // Carry register: synchronous clear has priority over a step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_cnt_nxt;
        end
    end

endmodule

// File: rtl/stoch_add_seq.sv
// Run controller for one stochastic bitstream adder: clears the carry,
// requests len bit pairs, optionally drains the carry, counts output ones.
module stoch_add_seq
    import stoch_pkg::*;
#(
    parameter int COUNTER_SIZE = 8,
    parameter int LEN_WIDTH    = 10
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              start,
    input  logic [LEN_WIDTH-1:0]              len,
    input  logic                              flush_en,
    input  logic                              a,
    input  logic                              b,
    output logic                              bit_req,
    output logic                              y,
    output logic                              y_valid,
    output logic                              busy,
    output logic                              done,
    output logic [LEN_WIDTH+COUNTER_SIZE-1:0] ones_count,
    output logic [COUNTER_SIZE-1:0]           residue,
    output logic                              sat
);

    localparam int OW = LEN_WIDTH + COUNTER_SIZE;

    state_t                  r_state;
    state_t                  w_next;
    logic [LEN_WIDTH-1:0]    r_len_cnt;
    logic                    r_flush;
    logic                    r_y;
    logic                    r_y_valid;
    logic [OW-1:0]           r_ones;
    logic [COUNTER_SIZE-1:0] r_residue;
    logic                    r_sat;

    logic                    w_step;
    logic                    w_run;
    logic                    w_clr;
    logic                    w_yc;
    logic                    w_sat;
    logic [COUNTER_SIZE-1:0] w_cnt_nxt;

    assign w_run  = (r_state == S_RUN);
    assign w_step = w_run || (r_state == S_FLUSH);
    assign w_clr  = (r_state == S_CLEAR);

    stoch_add_core #(
        .COUNTER_SIZE(COUNTER_SIZE)
    ) u_core (
        .i_clk     (CLK),
        .i_rst_n   (nRST),
        .i_clr     (w_clr),
        .i_en      (w_step),
        .i_a       (a & w_run),
        .i_b       (b & w_run),
        .o_yc      (w_yc),
        .o_cnt_nxt (w_cnt_nxt),
        .o_sat     (w_sat)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next  = r_state;
        bit_req = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (len != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                bit_req = 1'b1;
                if (r_len_cnt == LEN_WIDTH'(1)) begin
                    w_next = (r_flush && (w_cnt_nxt != '0))
                           ? S_FLUSH : S_WAIT;
                end
            end
            S_FLUSH: begin
                if (w_cnt_nxt == '0) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Run bookkeeping: length counter, output bit pipeline, result registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_len_cnt <= '0;
            r_flush   <= 1'b0;
            r_y       <= 1'b0;
            r_y_valid <= 1'b0;
            r_ones    <= '0;
            r_residue <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_y       <= w_step & w_yc;
            r_y_valid <= w_step;
            if (r_y_valid && r_y) begin
                r_ones <= r_ones + OW'(1);
            end
            if (w_step && w_sat) begin
                r_sat <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len_cnt <= len;
                        r_flush   <= flush_en;
                        if (len == '0) begin
                            r_ones    <= '0;
                            r_residue <= '0;
                            r_sat     <= 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    r_ones <= '0;
                    r_sat  <= 1'b0;
                end
                S_RUN: begin
                    r_len_cnt <= r_len_cnt - LEN_WIDTH'(1);
                    if (r_len_cnt == LEN_WIDTH'(1)) begin
                        r_residue <= w_cnt_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign y          = r_y;
    assign y_valid    = r_y_valid;
    assign ones_count = r_ones;
    assign residue    = r_residue;
    assign sat        = r_sat;

endmodule
